// File: rtl/nibble_serial_addsub_seq_pkg.sv
// Shared ALU definitions: sequencer state encoding, slice width and flag-vector layout.
// The flag indices are reused by the wider ALU flag logic.
package nibble_serial_addsub_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_C     = 0;
    localparam int FLAG_V     = 1;
    localparam int FLAG_Z     = 2;
    localparam int FLAG_N     = 3;
    localparam int FLAG_COUNT = 4;

    function automatic logic [FLAG_COUNT-1:0] pack_flags(
        input logic c,
        input logic v,
        input logic z,
        input logic n
    );
        logic [FLAG_COUNT-1:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        return f;
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_seq.sv
// WIDTH-bit add/subtract sequenced through one external 4-bit add/sub slice, LSB nibble first.
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_addsub_seq
    import nibble_serial_addsub_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    input  logic             in_cin,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_mode,
    output logic             slice_cin,
    input  logic [3:0]       slice_s,
    input  logic             slice_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t                r_state;
    logic [WIDTH-1:0]      r_a;
    logic [WIDTH-1:0]      r_b;
    logic                  r_mode;
    logic                  r_carry;
    logic [IDX_W-1:0]      r_idx;
    logic [WIDTH-1:0]      r_result;
    logic [FLAG_COUNT-1:0] r_flags;
    logic                  r_in_ready;
    logic                  r_out_valid;

    logic                  w_run;
    logic                  w_last;
    logic [NIBBLE_W-1:0]   w_a_nibs [NIBBLES];
    logic [NIBBLE_W-1:0]   w_b_nibs [NIBBLES];
    logic [WIDTH-1:0]      w_result_next;
    logic                  w_v_final;
    logic                  w_z_final;

    // Result nibble idx is replaced by the live slice sum; the rest are held.
    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign w_a_nibs[gi] = r_a[gi*NIBBLE_W +: NIBBLE_W];
            assign w_b_nibs[gi] = r_b[gi*NIBBLE_W +: NIBBLE_W];
            assign w_result_next[gi*NIBBLE_W +: NIBBLE_W] =
                (r_idx == IDX_W'(gi)) ? slice_s : r_result[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    assign w_run  = (r_state == RUN);
    assign w_last = (r_idx == LAST_IDX);

    assign slice_a    = w_run ? w_a_nibs[r_idx] : '0;
    assign slice_b    = w_run ? w_b_nibs[r_idx] : '0;
    assign slice_mode = w_run & r_mode;
    assign slice_cin  = w_run & r_carry;

    // A^B^mode^S at the MSB recovers the carry into the top bit; xor with carry-out gives overflow.
    assign w_v_final = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ r_mode ^ slice_s[NIBBLE_W-1] ^ slice_cout;
    assign w_z_final = (w_result_next == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_mode      <= 1'b0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_mode     <= in_mode;
                        r_carry    <= in_cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_result <= w_result_next;
                    r_carry  <= slice_cout;
                    if (w_last) begin
                        r_flags     <= pack_flags(slice_cout, w_v_final, w_z_final,
                                                  slice_s[NIBBLE_W-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_c      = r_flags[FLAG_C];
    assign out_v      = r_flags[FLAG_V];
    assign out_z      = r_flags[FLAG_Z];
    assign out_n      = r_flags[FLAG_N];

endmodule

// File: tb/tb_nibble_serial_addsub_seq.sv
// Bench for nibble_serial_addsub_seq: directed and random add/sub ops checked against
// whole-word arithmetic, with an arithmetic stand-in for the 4-bit add/sub slice.
module tb_nibble_serial_addsub_seq;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_mode;
    logic             in_cin;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic             slice_mode;
    logic             slice_cin;
    logic [3:0]       slice_s;
    logic             slice_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_c;
    logic             out_v;
    logic             out_z;
    logic             out_n;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_addsub_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_cin(in_cin),
        .slice_a(slice_a), .slice_b(slice_b), .slice_mode(slice_mode), .slice_cin(slice_cin),
        .slice_s(slice_s), .slice_cout(slice_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n)
    );

    // The slice: subtract mode inverts B inside the slice.
    logic [4:0] w_slice_sum;
    always_comb begin
        w_slice_sum = {1'b0, slice_a} + {1'b0, slice_b ^ {4{slice_mode}}} + {4'b0, slice_cin};
        slice_s     = w_slice_sum[3:0];
        slice_cout  = w_slice_sum[4];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic scramble_inputs(input logic allow_valid);
        in_valid = allow_valid ? 1'($urandom) : 1'b0;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        in_mode  = 1'($urandom);
        in_cin   = 1'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic mode, input logic cin, input int bp);
        logic [WIDTH-1:0] beff;
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] exp_res;
        logic [3:0]       exp_flags;
        logic [31:0]      low_sum;
        logic [31:0]      mask;
        logic [3:0]       nib_a;
        logic [3:0]       nib_b;
        int               waited;

        beff      = mode ? ~b : b;
        sum       = {1'b0, a} + {1'b0, beff} + {{WIDTH{1'b0}}, cin};
        exp_res   = sum[WIDTH-1:0];
        exp_flags = {exp_res[WIDTH-1],                                      // N
                     (exp_res == '0),                                       // Z
                     (a[WIDTH-1] == beff[WIDTH-1]) && (exp_res[WIDTH-1] != a[WIDTH-1]), // V
                     sum[WIDTH]};                                           // C

        check("idle_in_ready", 32'(in_ready), 32'(1));
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mode  = mode;
        in_cin   = cin;
        @(negedge clk);

        for (int k = 0; k < NIBBLES; k++) begin
            mask    = (32'd1 << (4 * k)) - 32'd1;
            low_sum = (32'(a) & mask) + (32'(beff) & mask) + 32'(cin);
            nib_a   = 4'(a >> (4 * k));
            nib_b   = 4'(b >> (4 * k));
            check("run_in_ready", 32'(in_ready), 32'(0));
            check("early_valid", 32'(out_valid), 32'(0));
            check("slice_a", 32'(slice_a), 32'(nib_a));
            check("slice_b", 32'(slice_b), 32'(nib_b));
            check("slice_mode", 32'(slice_mode), 32'(mode));
            check("slice_cin", 32'(slice_cin), 32'(low_sum >> (4 * k)));
            scramble_inputs(1'b1);
            @(negedge clk);
        end
        in_valid = 1'b0;

        check("latency_valid", 32'(out_valid), 32'(1));
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end

        for (int j = 0; j < bp; j++) begin
            check("bp_valid", 32'(out_valid), 32'(1));
            check("bp_in_ready", 32'(in_ready), 32'(0));
            check("bp_result", 32'(out_result), 32'(exp_res));
            check("bp_flags", 32'({out_n, out_z, out_v, out_c}), 32'(exp_flags));
            check("bp_slice_idle", 32'({slice_a, slice_b, slice_mode, slice_cin}), 32'(0));
            scramble_inputs(1'b1);
            @(negedge clk);
        end
        in_valid = 1'b0;

        check("result", 32'(out_result), 32'(exp_res));
        check("flags", 32'({out_n, out_z, out_v, out_c}), 32'(exp_flags));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'(0));
        check("post_in_ready", 32'(in_ready), 32'(1));
        $display("op a=%04h b=%04h mode=%0d cin=%0d bp=%0d -> result=%04h nzvc=%04b",
                 a, b, mode, cin, bp, out_result, {out_n, out_z, out_v, out_c});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
        check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        check({tag, "_result"}, 32'(out_result), 32'(0));
        check({tag, "_flags"}, 32'({out_n, out_z, out_v, out_c}), 32'(0));
        check({tag, "_slice"}, 32'({slice_a, slice_b, slice_mode, slice_cin}), 32'(0));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mode   = 1'b0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 5);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 2);

        // Reset two edges into a run; the op is discarded.
        in_valid = 1'b1;
        in_a     = 16'hABCD;
        in_b     = 16'h1357;
        in_mode  = 1'b0;
        in_cin   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midrun_reset");
        rst = 1'b0;
        run_op(16'h4321, 16'h1111, 1'b1, 1'b1, 0);

        for (int t = 0; t < 40; t++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
